// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster scanner that reads a frame buffer and drives
// syncs, data enable and pixel data one clock after each buffer read.
//
// Ports:
//   mem_rd_clk    pixel clock (all logic on rising edge)
//   mem_rd_rst_n  asynchronous active-low reset
//   scan_en       request to scan frames
//   mem_raddr     buffer read address
//   mem_rd_en     buffer read enable
//   mem_rdata     buffer read data, valid one clock after mem_rd_en
//   vga_hsync     active-low horizontal sync (aligned to mem_rdata)
//   vga_vsync     active-low vertical sync (aligned to mem_rdata)
//   vga_de        active-high data enable (aligned to mem_rdata)
//   vga_data      pixel out, zero outside the active area
//   frame_done    one-clock pulse on the last clock of a frame
//
// Build option: define VGA_SCAN_PIXEL_DOUBLE_EN to show each buffer pixel
// as a 2x2 block (H_ACTIVE and V_ACTIVE must be even).

module vga_scan_ctrl #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 19
) (
    input  logic                  mem_rd_clk,
    input  logic                  mem_rd_rst_n,
    input  logic                  scan_en,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  vga_de,
    output logic [DATA_WIDTH-1:0] vga_data,
    output logic                  frame_done
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [HW-1:0]           h_cnt_q, h_cnt_d;
    logic [VW-1:0]           v_cnt_q, v_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_next;
    logic                    rd_en_q, rd_en_d;
    logic                    frame_done_q, frame_done_d;
    logic                    hsync_q, vsync_q, de_q;
    logic                    scanning, h_end, frame_end, active, hs_raw, vs_raw;

    // Decode of the current raster position
    assign scanning  = (state_q != IDLE);
    assign h_end     = (h_cnt_q == HW'(H_TOTAL - 1));
    assign frame_end = h_end && (v_cnt_q == VW'(V_TOTAL - 1));
    assign active    = scanning && (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
    assign hs_raw    = !(scanning && (h_cnt_q >= HW'(H_ACTIVE + H_FP))
                                  && (h_cnt_q <= HW'(H_ACTIVE + H_FP + H_SYNC - 1)));
    assign vs_raw    = !(scanning && (v_cnt_q >= VW'(V_ACTIVE + V_FP))
                                  && (v_cnt_q <= VW'(V_ACTIVE + V_FP + V_SYNC - 1)));

    // Address advance for the pixel read this clock
    always_comb begin
        addr_next = addr_q;
`ifdef VGA_SCAN_PIXEL_DOUBLE_EN
        // Step on every odd pixel; the last pixel of an even line rewinds so
        // the following line re-reads the same buffer row.
        if (active && h_cnt_q[0]) begin
            if (!v_cnt_q[0] && (h_cnt_q == HW'(H_ACTIVE - 1)))
                addr_next = addr_q - ADDR_WIDTH'(H_ACTIVE / 2 - 1);
            else
                addr_next = addr_q + ADDR_WIDTH'(1);
        end
`else
        if (active)
            addr_next = addr_q + ADDR_WIDTH'(1);
`endif
    end

    // Next-state: FSM, counters, address and registered output decode
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (scan_en)
                    state_d = RUN;
            end
            RUN, DRAIN: begin
                if (frame_end) begin
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                    addr_d  = '0;
                    // A stop request landing on the last clock ends the scan here
                    state_d = (state_q == RUN && scan_en) ? RUN : IDLE;
                end else begin
                    h_cnt_d = h_end ? '0 : h_cnt_q + HW'(1);
                    if (h_end)
                        v_cnt_d = v_cnt_q + VW'(1);
                    addr_d  = addr_next;
                    state_d = scan_en ? RUN : DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                h_cnt_d = '0;
                v_cnt_d = '0;
                addr_d  = '0;
            end
        endcase

        rd_en_d      = (state_d != IDLE) && (h_cnt_d < HW'(H_ACTIVE))
                                         && (v_cnt_d < VW'(V_ACTIVE));
        frame_done_d = (state_d != IDLE) && (h_cnt_d == HW'(H_TOTAL - 1))
                                         && (v_cnt_d == VW'(V_TOTAL - 1));
    end

    // State and output registers
    always_ff @(posedge mem_rd_clk or negedge mem_rd_rst_n) begin
        if (!mem_rd_rst_n) begin
            state_q      <= IDLE;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            addr_q       <= '0;
            rd_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            de_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            addr_q       <= addr_d;
            rd_en_q      <= rd_en_d;
            frame_done_q <= frame_done_d;
            hsync_q      <= hs_raw;
            vsync_q      <= vs_raw;
            de_q         <= rd_en_q;
        end
    end

    assign mem_raddr  = addr_q;
    assign mem_rd_en  = rd_en_q;
    assign frame_done = frame_done_q;
    assign vga_hsync  = hsync_q;
    assign vga_vsync  = vsync_q;
    assign vga_de     = de_q;
    // Blank pixel data outside the delayed active window
    assign vga_data   = de_q ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a 8x5 raster (4x2 active, 40 clocks/frame).
module tb_vga_scan_ctrl;

    localparam int HA = 4;
    localparam int VA = 2;
    localparam int HT = 8;
    localparam int FRAME = 40;

    logic        clk;
    logic        rst_n;
    logic        scan_en;
    logic [18:0] mem_raddr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata;
    logic        vga_hsync, vga_vsync, vga_de;
    logic [7:0]  vga_data;
    logic        frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    vga_scan_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .DATA_WIDTH(8), .ADDR_WIDTH(19)
    ) dut (
        .mem_rd_clk  (clk),
        .mem_rd_rst_n(rst_n),
        .scan_en     (scan_en),
        .mem_raddr   (mem_raddr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_de      (vga_de),
        .vga_data    (vga_data),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: address-based pattern, garbage when not read
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= 8'hA0 + mem_raddr[7:0];
        else           mem_rdata <= 8'h5A;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hand-derived read address for position p (0..39) within a frame
    function automatic int exp_addr(input int p);
        int h = p % HT;
        int v = p / HT;
`ifdef VGA_SCAN_PIXEL_DOUBLE_EN
        if (v == 0) return (h < HA) ? h / 2 : 0;
        if (v == 1) return (h < HA) ? h / 2 : 2;
        return 2;
`else
        if (v < VA) return v * HA + ((h < HA) ? h : HA);
        return HA * VA;
`endif
    endfunction

    task automatic check_cycle(input int k);
        int p = k - 1;
        int h = p % HT;
        int v = p / HT;
        logic exp_de, exp_hs, exp_vs;
        logic [7:0] exp_data;
        chk($sformatf("rd_en k=%0d", k), 32'(mem_rd_en), 32'(h < HA && v < VA));
        chk($sformatf("raddr k=%0d", k), 32'(mem_raddr), 32'(exp_addr(p)));
        chk($sformatf("frame_done k=%0d", k), 32'(frame_done), 32'(k == FRAME));
        if (k == 1) begin
            exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
            exp_data = 8'h00;
        end else begin
            exp_de   = ((p - 1) % HT < HA) && ((p - 1) / HT < VA);
            exp_hs   = !(((p - 1) % HT == 5) || ((p - 1) % HT == 6));
            exp_vs   = !((p - 1) / HT == 3);
            exp_data = exp_de ? 8'(8'hA0 + exp_addr(p - 1)) : 8'h00;
        end
        chk($sformatf("hsync k=%0d", k), 32'(vga_hsync), 32'(exp_hs));
        chk($sformatf("vsync k=%0d", k), 32'(vga_vsync), 32'(exp_vs));
        chk($sformatf("de k=%0d", k), 32'(vga_de), 32'(exp_de));
        chk($sformatf("data k=%0d", k), 32'(vga_data), 32'(exp_data));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, " raddr"}, 32'(mem_raddr), 32'd0);
        chk({tag, " hsync"}, 32'(vga_hsync), 32'd1);
        chk({tag, " vsync"}, 32'(vga_vsync), 32'd1);
        chk({tag, " de"}, 32'(vga_de), 32'd0);
        chk({tag, " data"}, 32'(vga_data), 32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // Entered at the negedge of frame clock 1; leaves at the negedge after last_k
    task automatic run_frame(input int drop_at, input int last_k);
        for (int k = 1; k <= last_k; k++) begin
            check_cycle(k);
            if (k == drop_at) scan_en = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        scan_en = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("in_reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("idle_no_scan");

        // Frame 1 then frame 2 back to back; stop requested at clock 12 of frame 2
        scan_en = 1'b1;
        @(negedge clk);
        run_frame(0, FRAME);
        run_frame(12, FRAME);

        // Drained frame ended: block stays idle
        for (int i = 0; i < 4; i++) begin
            check_idle($sformatf("after_drain%0d", i));
            @(negedge clk);
        end

        // Restart from address 0, stop mid-frame with reset
        scan_en = 1'b1;
        @(negedge clk);
        run_frame(0, 9);
        check_cycle(10);
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clk);
        check_idle("held_reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0, FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
